// File: rtl/dma_desc_sched.sv
// -----------------------------------------------------------------------------
// dma_desc_sched
//
// Descriptor scheduler between the DMA CSR bank and the read/write streamers.
// A start pulse walks the descriptor table in index order. Disabled or
// zero-length entries are skipped. Each remaining descriptor is issued to both
// streamers, and the scheduler then waits for both done pulses. An abort or an
// AXI error stops the walk. The scheduler then drains outstanding AXI traffic
// and reports sticky done/error status.
//
// Optional build macro: DMA_DESC_IRQ_EN
//   When defined, adds desc_done_o[NUM_DESC]. This output gives a one-cycle
//   pulse on bit k when descriptor k is completed by both streamers.
//
// Ports:
//   clk               system clock
//   rst               asynchronous, active-low reset
//   dma_go_i          start pulse (accepted only while idle)
//   dma_abort_i       abort request (level or pulse)
//   desc_en_i         per-descriptor enable
//   desc_num_bytes_i  per-descriptor byte count, descriptor k at
//                     [k*BYTES_WIDTH +: BYTES_WIDTH]
//   rd_str_valid_o    read streamer request
//   rd_str_idx_o      descriptor index for the read streamer
//   rd_str_done_i     read streamer done pulse
//   wr_str_valid_o    write streamer request
//   wr_str_idx_o      descriptor index for the write streamer
//   wr_str_done_i     write streamer done pulse
//   err_valid_i       error report from the AXI interface
//   axi_idle_i        no AXI transactions outstanding
//   dma_active_o      scheduler busy (any state other than IDLE)
//   dma_done_o        sticky done status
//   dma_error_o       sticky error status
//   desc_done_o       (DMA_DESC_IRQ_EN only) per-descriptor completion pulse
// -----------------------------------------------------------------------------
module dma_desc_sched #(
  parameter  int NUM_DESC    = 2,
  parameter  int BYTES_WIDTH = 32,
  localparam int IDX_W       = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dma_go_i,
  input  logic                            dma_abort_i,
  input  logic [NUM_DESC-1:0]             desc_en_i,
  input  logic [NUM_DESC*BYTES_WIDTH-1:0] desc_num_bytes_i,
  output logic                            rd_str_valid_o,
  output logic [IDX_W-1:0]                rd_str_idx_o,
  input  logic                            rd_str_done_i,
  output logic                            wr_str_valid_o,
  output logic [IDX_W-1:0]                wr_str_idx_o,
  input  logic                            wr_str_done_i,
  input  logic                            err_valid_i,
  input  logic                            axi_idle_i,
  output logic                            dma_active_o,
  output logic                            dma_done_o,
  output logic                            dma_error_o
`ifdef DMA_DESC_IRQ_EN
  ,
  output logic [NUM_DESC-1:0]             desc_done_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DESC - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic             rd_seen_q, rd_seen_d;
  logic             wr_seen_q, wr_seen_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_valid_q, wr_valid_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  // A descriptor is worth issuing only if it is enabled and moves data.
  logic [NUM_DESC-1:0] desc_runnable;
  for (genvar gi = 0; gi < NUM_DESC; gi++) begin : g_runnable
    assign desc_runnable[gi] = desc_en_i[gi] &&
                               (desc_num_bytes_i[gi*BYTES_WIDTH +: BYTES_WIDTH] != '0);
  end

  logic stop_req;
  logic rd_hit, wr_hit;
  logic desc_retire;

  assign stop_req = dma_abort_i | err_valid_i;

  // A done pulse counts only while its request is outstanding.
  assign rd_hit = rd_str_done_i & rd_valid_q;
  assign wr_hit = wr_str_done_i & wr_valid_q;

  // The current descriptor retires when both sides have finished. Each side
  // may have finished earlier (seen flag) or may finish this cycle (pulse).
  // An abort or error in the same cycle wins over the retire.
  assign desc_retire = (state_q == ST_RUN) && !stop_req &&
                       (rd_seen_q | rd_hit) && (wr_seen_q | wr_hit);

  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    rd_seen_d  = rd_seen_q;
    wr_seen_d  = wr_seen_q;
    rd_valid_d = rd_valid_q;
    wr_valid_d = wr_valid_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      ST_IDLE: begin
        if (dma_go_i) begin
          done_d    = 1'b0;
          error_d   = 1'b0;
          cur_idx_d = '0;
          state_d   = ST_SEL;
        end
      end

      ST_SEL: begin
        if (stop_req) begin
          state_d = ST_DRAIN;
          if (err_valid_i) error_d = 1'b1;
        end else if (desc_runnable[cur_idx_q]) begin
          state_d    = ST_RUN;
          rd_valid_d = 1'b1;
          wr_valid_d = 1'b1;
        end else if (cur_idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          cur_idx_d = cur_idx_q + IDX_W'(1);
        end
      end

      ST_RUN: begin
        if (stop_req) begin
          state_d    = ST_DRAIN;
          rd_valid_d = 1'b0;
          wr_valid_d = 1'b0;
          rd_seen_d  = 1'b0;
          wr_seen_d  = 1'b0;
          if (err_valid_i) error_d = 1'b1;
        end else if (desc_retire) begin
          rd_valid_d = 1'b0;
          wr_valid_d = 1'b0;
          rd_seen_d  = 1'b0;
          wr_seen_d  = 1'b0;
          if (cur_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            cur_idx_d = cur_idx_q + IDX_W'(1);
            state_d   = ST_SEL;
          end
        end else begin
          if (rd_hit) begin
            rd_seen_d  = 1'b1;
            rd_valid_d = 1'b0;
          end
          if (wr_hit) begin
            wr_seen_d  = 1'b1;
            wr_valid_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        rd_valid_d = 1'b0;
        wr_valid_d = 1'b0;
        rd_seen_d  = 1'b0;
        wr_seen_d  = 1'b0;
        if (err_valid_i) error_d = 1'b1;
        if (axi_idle_i)  state_d = ST_DONE;
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registering "busy" from the next state keeps dma_active_o aligned with
    // the state register while remaining a flop output.
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cur_idx_q  <= '0;
      rd_seen_q  <= 1'b0;
      wr_seen_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      rd_seen_q  <= rd_seen_d;
      wr_seen_q  <= wr_seen_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      active_q   <= active_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rd_str_valid_o = rd_valid_q;
  assign wr_str_valid_o = wr_valid_q;
  // Both streamers always work on the same descriptor.
  assign rd_str_idx_o   = cur_idx_q;
  assign wr_str_idx_o   = cur_idx_q;
  assign dma_active_o   = active_q;
  assign dma_done_o     = done_q;
  assign dma_error_o    = error_q;

`ifdef DMA_DESC_IRQ_EN
  logic [NUM_DESC-1:0] desc_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      desc_done_q <= '0;
    end else begin
      desc_done_q <= '0;
      if (desc_retire) desc_done_q[cur_idx_q] <= 1'b1;
    end
  end

  assign desc_done_o = desc_done_q;
`else
  // No per-descriptor completion pulse in this build.
`endif

endmodule
